// File: rtl/wb_port_arbiter_if.sv
// Writeback bundle between the four register-file write sources and the port arbiter.
// Latency: none (wires only); the arbiter registers every output it drives.
// Backpressure: sources hold req until ack; stall from the control unit freezes new grants.
interface wb_port_arbiter_if #(
  parameter int DATA_W = 32
);
  // Source side: requests, per-source write data and the global stall
  logic [3:0]        req;
  logic [DATA_W-1:0] src_data0;
  logic [DATA_W-1:0] src_data1;
  logic [DATA_W-1:0] src_data2;
  logic [DATA_W-1:0] src_data3;
  logic              stall;

  // Arbiter side: grant pulse plus the register-bank write command
  logic [3:0]        ack;
  logic [2:0]        reg_control;
  logic              reg_write;
  logic [DATA_W-1:0] write_data;
  logic              busy;

  // Writeback sources / control unit
  modport master (
    output req,
    output src_data0,
    output src_data1,
    output src_data2,
    output src_data3,
    output stall,
    input  ack,
    input  reg_control,
    input  reg_write,
    input  write_data,
    input  busy
  );

  // Arbiter
  modport slave (
    input  req,
    input  src_data0,
    input  src_data1,
    input  src_data2,
    input  src_data3,
    input  stall,
    output ack,
    output reg_control,
    output reg_write,
    output write_data,
    output busy
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port among ALU, load, link and SP-update sources.
// Latency: req sampled in IDLE cycle N -> ack/reg_write in cycle N+1; at most one write per 2 cycles.
// Backpressure: stall blocks new grants in IDLE; losers hold req until acked. Optional WB_STATS_EN adds conflict_cnt.
module wb_port_arbiter #(
  parameter int DATA_W    = 32,
  parameter int PRIO_MODE = 0    // 0 = round-robin, 1 = fixed (src3 highest)
) (
  input  logic                   clk,
  input  logic                   reset,
  wb_port_arbiter_if.slave       wb
`ifdef WB_STATS_EN
  ,
  output logic [15:0]            conflict_cnt
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  // Destination-register mux codes per source
  localparam logic [2:0] CODE_RD   = 3'b001;  // src0: R-type rd field
  localparam logic [2:0] CODE_RT   = 3'b000;  // src1: load rt field
  localparam logic [2:0] CODE_R31  = 3'b011;  // src2: link register
  localparam logic [2:0] CODE_R29  = 3'b010;  // src3: stack pointer

  state_t            state_q, state_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [3:0]        ack_q, ack_d;
  logic              reg_write_q, reg_write_d;
  logic [2:0]        reg_control_q, reg_control_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic              busy_q, busy_d;

  // Winner of the current IDLE cycle
  logic              win_vld;
  logic [1:0]        win_idx;
  logic [1:0]        scan_idx;
  logic [2:0]        win_code;
  logic [DATA_W-1:0] win_data;
  logic              req_conflict;

`ifdef WB_STATS_EN
  logic [15:0]       conflict_cnt_q, conflict_cnt_d;
`endif

  // Pick the winning source: highest index in fixed mode, first set bit from rr_ptr in round-robin
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = 2'd0;
    scan_idx = 2'd0;
    if (PRIO_MODE == 1) begin
      // Ascending scan; the last set bit found is the highest index
      for (int i = 0; i < 4; i++) begin
        if (wb.req[i]) begin
          win_vld = 1'b1;
          win_idx = 2'(i);
        end
      end
    end else begin
      // Descending offset scan; the last hit is the one closest to rr_ptr
      for (int k = 3; k >= 0; k--) begin
        scan_idx = rr_ptr_q + 2'(k);
        if (wb.req[scan_idx]) begin
          win_vld = 1'b1;
          win_idx = scan_idx;
        end
      end
    end
  end

  // Map the winner to its mux code and write data
  always_comb begin
    win_code = CODE_RT;
    win_data = '0;
    case (win_idx)
      2'd0: begin win_code = CODE_RD;  win_data = wb.src_data0; end
      2'd1: begin win_code = CODE_RT;  win_data = wb.src_data1; end
      2'd2: begin win_code = CODE_R31; win_data = wb.src_data2; end
      default: begin win_code = CODE_R29; win_data = wb.src_data3; end
    endcase
  end

  // Two or more sources competing at the same grant edge
  always_comb begin
    req_conflict = (({2'b00, wb.req[0]} + {2'b00, wb.req[1]} +
                     {2'b00, wb.req[2]} + {2'b00, wb.req[3]}) >= 3'd2);
  end

  // Next-state and registered-output logic for the IDLE/WRITE sequencer
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    ack_d         = 4'b0000;
    reg_write_d   = 1'b0;
    busy_d        = 1'b0;
    reg_control_d = reg_control_q;
    write_data_d  = write_data_q;
`ifdef WB_STATS_EN
    conflict_cnt_d = conflict_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (!wb.stall && win_vld) begin
          state_d       = WRITE;
          ack_d         = 4'b0001 << win_idx;
          reg_write_d   = 1'b1;
          busy_d        = 1'b1;
          reg_control_d = win_code;
          write_data_d  = win_data;
          if (PRIO_MODE == 0) begin
            rr_ptr_d = win_idx + 2'd1;
          end
`ifdef WB_STATS_EN
          if (req_conflict && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
          end
`endif
        end
      end
      WRITE: begin
        // Single write cycle; stall has no effect here, mux code and data stay put
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= 2'd0;
      ack_q         <= 4'b0000;
      reg_write_q   <= 1'b0;
      reg_control_q <= 3'b000;
      write_data_q  <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      ack_q         <= ack_d;
      reg_write_q   <= reg_write_d;
      reg_control_q <= reg_control_d;
      write_data_q  <= write_data_d;
      busy_q        <= busy_d;
    end
  end

`ifdef WB_STATS_EN
  // Saturating count of grants that had at least one losing requester
  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_cnt_q <= 16'd0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
`else
  // Conflict detection only feeds the statistics counter
  logic unused_conflict;
  assign unused_conflict = req_conflict;
`endif

  assign wb.ack         = ack_q;
  assign wb.reg_write   = reg_write_q;
  assign wb.reg_control = reg_control_q;
  assign wb.write_data  = write_data_q;
  assign wb.busy        = busy_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for the writeback port arbiter: round-robin and fixed-priority instances side by side.
// Expected grants are queued when requests are raised and compared as reg_write pulses appear.
// Sources drop req once they see their ack; stall and reset are driven directly.
module tb_wb_port_arbiter;

  typedef struct {
    logic [3:0]  ack;
    logic [2:0]  code;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  exp_t q_rr[$];
  exp_t q_fx[$];
  int   rr_grant_cyc[$];

  wb_port_arbiter_if #(.DATA_W(32)) if_rr ();
  wb_port_arbiter_if #(.DATA_W(32)) if_fx ();

`ifdef WB_STATS_EN
  logic [15:0] cc_rr;
  logic [15:0] cc_fx;
`endif

  wb_port_arbiter #(.DATA_W(32), .PRIO_MODE(0)) dut_rr (
    .clk(clk),
    .reset(reset),
    .wb(if_rr)
`ifdef WB_STATS_EN
    , .conflict_cnt(cc_rr)
`endif
  );

  wb_port_arbiter #(.DATA_W(32), .PRIO_MODE(1)) dut_fx (
    .clk(clk),
    .reset(reset),
    .wb(if_fx)
`ifdef WB_STATS_EN
    , .conflict_cnt(cc_fx)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] code_of(input int src);
    case (src)
      0:       return 3'b001;
      1:       return 3'b000;
      2:       return 3'b011;
      default: return 3'b010;
    endcase
  endfunction

  function automatic exp_t mk(input int src, input logic [31:0] data);
    exp_t e;
    e.ack  = 4'b0001 << src;
    e.code = code_of(src);
    e.data = data;
    return e;
  endfunction

  // Observe one instance after the clock edge: score writes, let acked sources drop req
  task automatic mon(input int id);
    logic [3:0]  a;
    logic        w;
    logic [2:0]  c;
    logic [31:0] d;
    logic        b;
    exp_t        e;
    if (id == 0) begin
      a = if_rr.ack; w = if_rr.reg_write; c = if_rr.reg_control; d = if_rr.write_data; b = if_rr.busy;
    end else begin
      a = if_fx.ack; w = if_fx.reg_write; c = if_fx.reg_control; d = if_fx.write_data; b = if_fx.busy;
    end
    if (w) begin
      if ((id == 0 && q_rr.size() == 0) || (id == 1 && q_fx.size() == 0)) begin
        check($sformatf("unexpected_write_dut%0d_ack", id), {60'd0, a}, 64'd0);
      end else begin
        if (id == 0) e = q_rr.pop_front();
        else         e = q_fx.pop_front();
        check($sformatf("ack_dut%0d", id),  {60'd0, a}, {60'd0, e.ack});
        check($sformatf("code_dut%0d", id), {61'd0, c}, {61'd0, e.code});
        check($sformatf("data_dut%0d", id), {32'd0, d}, {32'd0, e.data});
        check($sformatf("busy_dut%0d", id), {63'd0, b}, 64'd1);
      end
      if (id == 0) begin
        if_rr.req = if_rr.req & ~a;
        rr_grant_cyc.push_back(cyc);
      end else begin
        if_fx.req = if_fx.req & ~a;
      end
    end else begin
      check($sformatf("idle_ack_dut%0d", id),  {60'd0, a}, 64'd0);
      check($sformatf("idle_busy_dut%0d", id), {63'd0, b}, 64'd0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    mon(0);
    mon(1);
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((q_rr.size() != 0 || q_fx.size() != 0 || if_rr.req != 4'b0 || if_fx.req != 4'b0) && n < max) begin
      step();
      n++;
    end
    check("drain_timeout", {63'd0, (n >= max)}, 64'd0);
    step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rr_wr"},   {63'd0, if_rr.reg_write},   64'd0);
    check({tag, "_rr_ack"},  {60'd0, if_rr.ack},         64'd0);
    check({tag, "_rr_busy"}, {63'd0, if_rr.busy},        64'd0);
    check({tag, "_rr_ctl"},  {61'd0, if_rr.reg_control}, 64'd0);
    check({tag, "_rr_data"}, {32'd0, if_rr.write_data},  64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    if_rr.req = 4'b0; if_rr.stall = 1'b0;
    if_rr.src_data0 = '0; if_rr.src_data1 = '0; if_rr.src_data2 = '0; if_rr.src_data3 = '0;
    if_fx.req = 4'b0; if_fx.stall = 1'b0;
    if_fx.src_data0 = '0; if_fx.src_data1 = '0; if_fx.src_data2 = '0; if_fx.src_data3 = '0;
    @(negedge clk);
    step();
    step();
    // Reset state
    check_reset_vals("reset");
    check("reset_fx_wr", {63'd0, if_fx.reg_write}, 64'd0);
    check("reset_fx_ack", {60'd0, if_fx.ack}, 64'd0);
`ifdef WB_STATS_EN
    check("reset_cc", {48'd0, cc_rr}, 64'd0);
`endif
    reset = 1'b0;
    step();

    // Single load writeback: one-cycle latency, one-cycle pulse
    if_rr.src_data1 = 32'hDEADBEEF;
    if_rr.req = 4'b0010;
    q_rr.push_back(mk(1, 32'hDEADBEEF));
    step();
    check("t1_wr_high", {63'd0, if_rr.reg_write}, 64'd1);
    step();
    check("t1_wr_low", {63'd0, if_rr.reg_write}, 64'd0);
    check("t1_ack_low", {60'd0, if_rr.ack}, 64'd0);
    drain(10);

    // Round-robin with all four requesting from a fresh pointer
    do_reset();
    rr_grant_cyc.delete();
    if_rr.src_data0 = 32'h1111_0000;
    if_rr.src_data1 = 32'h2222_0001;
    if_rr.src_data2 = 32'h3333_0002;
    if_rr.src_data3 = 32'h4444_0003;
    if_rr.req = 4'b1111;
    q_rr.push_back(mk(0, 32'h1111_0000));
    q_rr.push_back(mk(1, 32'h2222_0001));
    q_rr.push_back(mk(2, 32'h3333_0002));
    q_rr.push_back(mk(3, 32'h4444_0003));
    drain(20);
    check("t2_grant_count", rr_grant_cyc.size(), 64'd4);
    if (rr_grant_cyc.size() == 4) begin
      for (int i = 1; i < 4; i++) begin
        check($sformatf("t2_spacing%0d", i), rr_grant_cyc[i] - rr_grant_cyc[i-1], 64'd2);
      end
    end
`ifdef WB_STATS_EN
    check("t2_conflict_cnt", {48'd0, cc_rr}, 64'd3);
`endif

    // Fixed priority: src2 beats src0
    if_fx.src_data0 = 32'hA0A0_0000;
    if_fx.src_data2 = 32'hC2C2_0002;
    if_fx.req = 4'b0101;
    q_fx.push_back(mk(2, 32'hC2C2_0002));
    q_fx.push_back(mk(0, 32'hA0A0_0000));
    drain(20);

    // Stall holds off a pending SP update for three cycles
    if_rr.src_data3 = 32'h0000_7FF0;
    if_rr.stall = 1'b1;
    if_rr.req = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("t4_stall_wr%0d", i), {63'd0, if_rr.reg_write}, 64'd0);
    end
    if_rr.stall = 1'b0;
    q_rr.push_back(mk(3, 32'h0000_7FF0));
    step();
    check("t4_release_wr", {63'd0, if_rr.reg_write}, 64'd1);
    drain(10);

    // Reset during the WRITE cycle of a link grant truncates it
    if_rr.src_data2 = 32'h0040_0104;
    if_rr.req = 4'b0100;
    q_rr.push_back(mk(2, 32'h0040_0104));
    step();
    check("t5_in_write", {63'd0, if_rr.busy}, 64'd1);
    reset = 1'b1;
    step();
    check_reset_vals("t5_after_reset");
    reset = 1'b0;
    if_rr.src_data0 = 32'h5555_0000;
    if_rr.src_data1 = 32'h6666_0001;
    if_rr.req = 4'b0011;
    q_rr.push_back(mk(0, 32'h5555_0000));
    q_rr.push_back(mk(1, 32'h6666_0001));
    drain(20);

    // Pointer must return to 0 even when it was left at 1 before reset
    if_rr.src_data0 = 32'h7777_0000;
    if_rr.req = 4'b0001;
    q_rr.push_back(mk(0, 32'h7777_0000));
    step();
    reset = 1'b1;
    step();
    check_reset_vals("t6_after_reset");
    reset = 1'b0;
    if_rr.src_data0 = 32'h8888_0000;
    if_rr.src_data1 = 32'h9999_0001;
    if_rr.req = 4'b0011;
    q_rr.push_back(mk(0, 32'h8888_0000));
    q_rr.push_back(mk(1, 32'h9999_0001));
    drain(20);

`ifdef WB_STATS_EN
    // Saturation of the conflict counter
    force dut_rr.conflict_cnt_q = 16'hFFFF;
    #1;
    release dut_rr.conflict_cnt_q;
    if_rr.req = 4'b0011;
    q_rr.push_back(mk(0, 32'h8888_0000));
    q_rr.push_back(mk(1, 32'h9999_0001));
    drain(20);
    check("t7_saturate", {48'd0, cc_rr}, 64'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
